io_bus_arbiter: RTL

- Shares the single memory-mapped I/O bus (abus/dbus/wren) between two masters: m0 = processor core, m1 = auxiliary master (debug/DMA/pattern engine).
- Drives the bus seen by all I/O devices (LEDR at 0xF0000004, switches, keys, timer).
- Collects the OR-combined device read data, which devices register one clock after the address.
- Two-way round-robin arbitration with a burst cap, so neither master starves the other.

---
 rtl/io_bus_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 23 ++
 rtl/io_bus_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/io_bus_pkg.sv
// ============================================================================
// Module      : io_bus_pkg
// Description : Shared types and constants for the I/O bus arbiter slice.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package io_bus_pkg;

  localparam int          c_BUS_W     = 32;
  localparam logic [31:0] c_IDLE_ADDR = 32'h0000_0000;

  // Device map on the shared I/O bus
  localparam logic [31:0] c_LEDR_ADDR  = 32'hF000_0004;
  localparam logic [31:0] c_KEY_ADDR   = 32'hF000_0010;
  localparam logic [31:0] c_SW_ADDR    = 32'hF000_0014;
  localparam logic [31:0] c_TIMER_ADDR = 32'hF000_0020;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Combinational two-way picker; ptr_i = 1 favours requester 1.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] pick_o
);

  always_comb begin
    pick_o = req_i;
    if (req_i == 2'b11) begin
      pick_o = ptr_i ? 2'b10 : 2'b01;
    end
  end

endmodule

`default_nettype wire

// File: rtl/io_bus_arbiter.sv
// ============================================================================
// Module      : io_bus_arbiter
// Description : Two-master arbiter for the shared I/O bus with burst cap and
//               tagged read return. IOARB_FIXED_PRIO_EN selects m0 priority.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int          MAX_BURST = 8,
  parameter logic [31:0] IDLE_ADDR = c_IDLE_ADDR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_wren,
  input  logic [c_BUS_W-1:0]  m0_abus,
  input  logic [c_BUS_W-1:0]  m0_dbus,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [c_BUS_W-1:0]  m0_rdata,
  input  logic                m1_req,
  input  logic                m1_wren,
  input  logic [c_BUS_W-1:0]  m1_abus,
  input  logic [c_BUS_W-1:0]  m1_dbus,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [c_BUS_W-1:0]  m1_rdata,
  output logic [c_BUS_W-1:0]  abus,
  output logic [c_BUS_W-1:0]  dbus,
  output logic                wren,
  input  logic [c_BUS_W-1:0]  dbusin
);

  localparam logic [7:0] c_BURST_LAST = 8'(MAX_BURST - 1);

  arb_state_e         state_q, state_d;
  logic [7:0]         burst_q, burst_d;
  logic [1:0]         w_req, w_pick;
  logic               w_force0, w_force1;
  logic               w_acc0, w_acc1;
  logic               rd_vld_q, rd_tag_q;
  logic [c_BUS_W-1:0] rdata0_q, rdata1_q;

  assign w_req    = {m1_req, m0_req};
  assign w_force1 = (burst_q == c_BURST_LAST);

`ifdef IOARB_FIXED_PRIO_EN
  assign w_pick   = w_req[0] ? 2'b01 : {w_req[1], 1'b0};
  assign w_force0 = 1'b0;
`else
  logic ptr_q, ptr_d;

  assign w_force0 = (burst_q == c_BURST_LAST);

  rr_arb2 u_rr_arb2 (
    .req_i  (w_req),
    .ptr_i  (ptr_q),
    .pick_o (w_pick)
  );

  // Entering an owner state hands the next tie to the other master
  always_comb begin
    ptr_d = ptr_q;
    if (state_d != state_q) begin
      if (state_d == ST_OWN0) ptr_d = 1'b1;
      else if (state_d == ST_OWN1) ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_pick[0])      state_d = ST_OWN0;
        else if (w_pick[1]) state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (!m0_req)                  state_d = m1_req ? ST_OWN1 : ST_IDLE;
        else if (m1_req && w_force0)  state_d = ST_OWN1;
      end
      ST_OWN1: begin
        if (!m1_req)                  state_d = m0_req ? ST_OWN0 : ST_IDLE;
        else if (m0_req && w_force1)  state_d = ST_OWN0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Counter parks at the cap while unopposed so it never wraps
    if (state_d != state_q)                                   burst_d = '0;
    else if (state_q != ST_IDLE && burst_q != c_BURST_LAST)   burst_d = burst_q + 8'd1;
    else                                                      burst_d = burst_q;
  end

  always_comb begin
    m0_gnt = (state_q == ST_OWN0);
    m1_gnt = (state_q == ST_OWN1);
    w_acc0 = m0_gnt & m0_req;
    w_acc1 = m1_gnt & m1_req;
    abus   = IDLE_ADDR;
    dbus   = '0;
    wren   = 1'b0;
    if (w_acc0) begin
      abus = m0_abus;
      dbus = m0_dbus;
      wren = m0_wren;
    end else if (w_acc1) begin
      abus = m1_abus;
      dbus = m1_dbus;
      wren = m1_wren;
    end
  end

  // Return tag is captured at issue so a hand-over cannot misroute data
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q <= 1'b0;
      rd_tag_q <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rd_vld_q <= (w_acc0 & ~m0_wren) | (w_acc1 & ~m1_wren);
      rd_tag_q <= w_acc1;
      if (m0_rvalid) rdata0_q <= dbusin;
      if (m1_rvalid) rdata1_q <= dbusin;
    end
  end

  assign m0_rvalid = rd_vld_q & ~rd_tag_q;
  assign m1_rvalid = rd_vld_q &  rd_tag_q;
  assign m0_rdata  = m0_rvalid ? dbusin : rdata0_q;
  assign m1_rdata  = m1_rvalid ? dbusin : rdata1_q;

endmodule

`default_nettype wire
